// File: rtl/pingpong_iq_buffer.sv
// Multi-bank symbol buffer: the writer fills I/Q banks in ring order and the reader streams each closed bank.
// Latency: first sample on rd_valid 2 cycles after the bank closes, then 1 sample/cycle with rd_ready high.
// Backpressure: wr_ready drops while the next write bank is unread; output holds while rd_valid && !rd_ready.
module pingpong_iq_buffer #(
    parameter int DATA_WIDTH = 18,
    parameter int DEPTH      = 1200,
    parameter int NUM_BANKS  = 2,
    localparam int ADDR_W    = $clog2(DEPTH),
    localparam int LEN_W     = $clog2(DEPTH + 1),
    localparam int CNT_W     = $clog2(NUM_BANKS + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data_r,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  wr_last,
    output logic                  wr_ready,
    input  logic                  rd_ready,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data_r,
    output logic [DATA_WIDTH-1:0] rd_data_i,
    output logic                  rd_last,
    output logic [LEN_W-1:0]      rd_len,
    output logic                  overflow,
    output logic [CNT_W-1:0]      banks_full
);

    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int MEM_AW = $clog2(NUM_BANKS * DEPTH);
    localparam int SW     = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {RD_IDLE, RD_FETCH, RD_STREAM} rd_state_t;

    logic [SW-1:0]        mem [NUM_BANKS*DEPTH];
    logic [NUM_BANKS-1:0] full;
    logic [LEN_W-1:0]     bank_len [NUM_BANKS];
    logic [BANK_W-1:0]    wbank, rbank;
    logic [ADDR_W-1:0]    waddr, raddr;
    logic [SW-1:0]        rd_q;
    logic [MEM_AW-1:0]    wr_mem_addr, rd_mem_addr;
    rd_state_t            state, state_nxt;
    logic                 wr_acc, wr_close, at_last;
    logic                 rd_start, rd_load, rd_adv, rd_done;

    function automatic logic [BANK_W-1:0] next_bank(input logic [BANK_W-1:0] b);
        return (b == BANK_W'(NUM_BANKS - 1)) ? '0 : b + 1'b1;
    endfunction

    assign wr_ready = enable && !full[wbank];
    assign wr_acc   = wr_valid && wr_ready;
    // A bank closes on wr_last or when its last slot is written.
    assign wr_close = wr_acc && (wr_last || waddr == ADDR_W'(DEPTH - 1));
    assign at_last  = (LEN_W'(raddr) + LEN_W'(1)) == bank_len[rbank];

    assign wr_mem_addr = MEM_AW'(int'(wbank) * DEPTH + int'(waddr));
    assign rd_mem_addr = MEM_AW'(int'(rbank) * DEPTH + int'(raddr) + (rd_adv ? 1 : 0));

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_mem_addr] <= {wr_data_r, wr_data_i};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            waddr    <= '0;
            wbank    <= '0;
            overflow <= 1'b0;
        end else if (wr_acc) begin
            if (wr_close) begin
                waddr <= '0;
                wbank <= next_bank(wbank);
                if (!wr_last) begin
                    overflow <= 1'b1;
                end
            end else begin
                waddr <= waddr + 1'b1;
            end
        end
    end

    // Writer and reader never own the same bank, so set and clear cannot collide.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full <= '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                bank_len[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (wr_close && wbank == BANK_W'(b)) begin
                    full[b]     <= 1'b1;
                    bank_len[b] <= LEN_W'(waddr) + LEN_W'(1);
                end else if (rd_done && rbank == BANK_W'(b)) begin
                    full[b] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RD_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (enable) begin
            case (state)
                RD_IDLE:   if (full[rbank]) state_nxt = RD_FETCH;
                RD_FETCH:  state_nxt = RD_STREAM;
                RD_STREAM: if (rd_ready && at_last) state_nxt = RD_IDLE;
                default:   state_nxt = RD_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_valid = (state == RD_STREAM);
        rd_start = enable && (state == RD_IDLE) && full[rbank];
        rd_load  = enable && (state == RD_FETCH);
        rd_adv   = enable && rd_valid && rd_ready && !at_last;
        rd_done  = enable && rd_valid && rd_ready && at_last;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            raddr <= '0;
            rbank <= '0;
            rd_q  <= '0;
        end else begin
            if (rd_start) begin
                raddr <= '0;
            end else if (rd_adv) begin
                raddr <= raddr + 1'b1;
            end
            if (rd_load || rd_adv) begin
                rd_q <= mem[rd_mem_addr];
            end
            if (rd_done) begin
                rbank <= next_bank(rbank);
            end
        end
    end

    always_comb begin
        banks_full = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            banks_full = banks_full + CNT_W'(full[b]);
        end
    end

    assign rd_data_r = rd_q[SW-1:DATA_WIDTH];
    assign rd_data_i = rd_q[DATA_WIDTH-1:0];
    assign rd_last   = rd_valid && at_last;
    assign rd_len    = rd_valid ? bank_len[rbank] : '0;

endmodule
